// File: rtl/irq_loopback_pkg.sv
// Purpose: shared types and default parameter values for the IRQ loopback queue.
// Contents: echo FSM state enum, default parameter constants.
package irq_loopback_pkg;

  // Per-channel echo sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_GAP   = 2'd2
  } echo_state_e;

  localparam int unsigned DEF_CPU_NB         = 4;
  localparam int unsigned DEF_IRQ_W          = 32;
  localparam int unsigned DEF_TRANSACTION_NB = 1000;
  localparam int unsigned DEF_DEPTH          = 4;
  localparam int unsigned DEF_ECHO_GAP       = 0;

endpackage

// File: rtl/irq_loopback_fifo.sv
// Purpose: single-channel circular queue of IRQ vectors.
// Ports: clk, rst (async, active-high); push/wdata write the tail; pop advances
//        the head; head_c is the current head entry; level_c is the occupancy;
//        full/empty are derived from the pointers.
module irq_loopback_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IRQ_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [IRQ_W-1:0]           wdata,
  output logic [IRQ_W-1:0]           head_c,
  output logic [$clog2(DEPTH):0]     level_c,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [IRQ_W-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // Extra pointer MSB tells a full queue from an empty one
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level_c = wptr - rptr;
  assign head_c  = mem[rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage; head is read before the edge, so push+pop on a full queue is safe
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/irq_loopback_queue.sv
// Purpose: per-channel IRQ change detector that queues each change and echoes
//          it back, with optional idle gap between echoes.
// Ports: clk, rst (async, active-high); i_irq[CPU_NB] incoming vectors;
//        o_irq[CPU_NB] echoed vectors; o_finish per-channel done;
//        o_overflow per-channel sticky drop; o_all_finish = AND of o_finish.
module irq_loopback_queue
  import irq_loopback_pkg::*;
#(
  parameter int unsigned CPU_NB         = DEF_CPU_NB,
  parameter int unsigned IRQ_W          = DEF_IRQ_W,
  parameter int unsigned TRANSACTION_NB = DEF_TRANSACTION_NB,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned ECHO_GAP       = DEF_ECHO_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IRQ_W-1:0]  i_irq [CPU_NB],
  output logic [IRQ_W-1:0]  o_irq [CPU_NB],
  output logic [CPU_NB-1:0] o_finish,
  output logic [CPU_NB-1:0] o_overflow,
  output logic              o_all_finish
);

  localparam int unsigned CW = $clog2(TRANSACTION_NB + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (ECHO_GAP > 1) ? $clog2(ECHO_GAP) : 1;

  assign o_all_finish = &o_finish;

  for (genvar c = 0; c < CPU_NB; c++) begin : g_ch
    logic [IRQ_W-1:0] prev;
    logic [IRQ_W-1:0] head;
    logic [IRQ_W-1:0] echo;
    logic [CW-1:0]    rcv;
    logic [AW:0]      level;
    logic [GW-1:0]    gap_cnt;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             remain;
    logic             done;
    logic             dropped;
    echo_state_e      state;

    // A change is accepted until the receive budget is spent
    assign accept = (i_irq[c] != prev) && (rcv < CW'(TRANSACTION_NB));
    assign pop    = (state == ST_READY);
    assign push   = accept && (!full || pop);
    // Occupancy after this edge, including a same-edge push
    assign remain = (level + (AW+1)'(push) - (AW+1)'(pop)) != '0;

    irq_loopback_fifo #(
      .DEPTH (DEPTH),
      .IRQ_W (IRQ_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wdata   (i_irq[c]),
      .head_c  (head),
      .level_c (level),
      .full    (full),
      .empty   (empty)
    );

    // Change detection, accounting and echo sequencing
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev    <= '0;
        rcv     <= '0;
        echo    <= '0;
        done    <= 1'b0;
        dropped <= 1'b0;
        gap_cnt <= '0;
        state   <= ST_IDLE;
      end else begin
        prev <= i_irq[c];
        if (accept)         rcv     <= rcv + CW'(1);
        if (accept && !push) dropped <= 1'b1;
        if ((rcv == CW'(TRANSACTION_NB)) && empty && (state != ST_READY)) done <= 1'b1;

        case (state)
          ST_IDLE: begin
            if (remain) state <= ST_READY;
          end
          ST_READY: begin
            echo <= head;
            if (ECHO_GAP != 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else if (!remain) begin
              state <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (gap_cnt == GW'(ECHO_GAP - 1)) begin
              state <= remain ? ST_READY : ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign o_irq[c]      = echo;
    assign o_finish[c]   = done;
    assign o_overflow[c] = dropped;
  end

endmodule

// File: doc/irq_loopback_queue.md
IRQ_LOOPBACK_QUEUE -- requirements
Module: irq_loopback_queue

Interface
REQ-001 SHALL have parameter CPU_NB, default 4: number of independent IRQ channels.
REQ-002 SHALL have parameter IRQ_W, default 32: IRQ vector width per channel.
REQ-003 SHALL have parameter TRANSACTION_NB, default 1000: IRQ changes accepted per channel.
REQ-004 SHALL have parameter DEPTH, default 4: per-channel queue depth, power of two, at least 2.
REQ-005 SHALL have parameter ECHO_GAP, default 0: minimum idle cycles between consecutive echoes on one channel.
REQ-006 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_irq, input, unpacked [CPU_NB] of IRQ_W, incoming IRQ vectors.
REQ-009 SHALL have port o_irq, output, unpacked [CPU_NB] of IRQ_W, echoed IRQ vectors.
REQ-010 SHALL have port o_finish, output, CPU_NB, per-channel done flag.
REQ-011 SHALL have port o_overflow, output, CPU_NB, per-channel sticky drop flag.
REQ-012 SHALL have port o_all_finish, output, 1, AND of all o_finish bits.

Function
REQ-013 Per channel, SHALL register i_irq into a previous-value register each cycle; a change is i_irq != previous.
REQ-014 While the received count is below TRANSACTION_NB, each change SHALL be counted and pushed into that channel's queue in the same edge.
REQ-015 Changes after TRANSACTION_NB received SHALL be ignored: no push, no count.
REQ-016 If the queue is full and no pop happens in the same edge, the change SHALL be dropped, still counted, and o_overflow set until reset.
REQ-017 A push and a pop in the same edge on a full queue SHALL both succeed; there is no drop.
REQ-018 Echo FSM per channel SHALL have states IDLE (queue empty), READY (entry present, may pop), and GAP (counting ECHO_GAP cycles after a pop).
REQ-019 In READY, SHALL pop the head entry and load it into o_irq; transition to GAP if ECHO_GAP>0, else stay READY if entries remain, else IDLE.
REQ-020 GAP SHALL last exactly ECHO_GAP cycles, then go to READY if the queue is non-empty, else IDLE.
REQ-021 Latency: a change sampled at edge N SHALL appear on o_irq no earlier than edge N+1; with an empty queue and IDLE state, exactly edge N+1.
REQ-022 o_irq SHALL hold the last echoed value between pops.
REQ-023 o_finish[c] SHALL assert when received count equals TRANSACTION_NB and the queue is empty and the FSM is not in READY, then stay high until reset.
REQ-024 Received counter SHALL be sized $clog2(TRANSACTION_NB+1) bits and SHALL saturate at TRANSACTION_NB.
REQ-025 Queue pointers SHALL wrap modulo DEPTH, with an extra bit to distinguish full from empty.
REQ-026 Channels SHALL be fully independent; no cross-channel ordering is implied.

Reset
REQ-027 On rst, o_irq, previous registers, counters, pointers, o_finish and o_overflow SHALL be 0, and all FSMs SHALL be IDLE, regardless of clk.
REQ-028 Reset mid-operation SHALL discard queued entries; the first cycle after release compares i_irq against 0.
REQ-029 The block SHALL NOT call $finish; simulation end is owned by the testbench via o_all_finish.

Structure
REQ-030 Package irq_loopback_pkg SHALL hold the echo FSM state enum and the default parameter constants.
REQ-031 Sub-module irq_loopback_fifo SHALL implement one per-channel queue (parameters DEPTH, IRQ_W; push, pop, full, empty); it SHALL be instantiated CPU_NB times in a generate loop.

Verification
REQ-032 CPU_NB=1, ECHO_GAP=0: i_irq goes 0 -> 0xA5 at edge 5 -> o_irq = 0xA5 at edge 6.
REQ-033 DEPTH=4, ECHO_GAP=3: five changes on consecutive cycles -> echoes spaced 4 cycles apart, in order, with no overflow.
REQ-034 DEPTH=2, ECHO_GAP=7: four back-to-back changes -> the 4th is dropped, o_overflow=1, and only 3 values are echoed.
REQ-035 TRANSACTION_NB=3: five changes -> three values echoed, o_finish=1 after the last echo, and the 4th and 5th are ignored.
REQ-036 CPU_NB=4, distinct change patterns per channel -> per-channel echoes match; o_all_finish asserts only after the slowest channel finishes.
REQ-037 rst pulse while 2 entries are queued -> o_irq=0 immediately, and no stale entry is echoed after release.
